laser_scheduler: RTL and testbench

Shared-laser controller for the four spaceship cannons (up, down, left, right). It captures fire requests from the four buttons, picks one with round-robin arbitration, and drives the single laser position counter down the granted tunnel. On each movement tick it resolves a hit against the monster in that tunnel, or a miss at the screen edge, then enforces a cooldown before the next shot. It sits between the button inputs / monster state and the VGA renderer, which draws the laser from `laser_pos` and `shooting`.

---
 rtl/laser_pkg.sv | 22 ++
 rtl/laser_scheduler_rr_arbiter4.sv | 26 ++
 rtl/laser_scheduler.sv | 122 ++++++++++++
 tb/tb_laser_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared types and constants for the laser scheduler: tunnel directions,
// FSM state encoding and the laser position width.
package laser_pkg;

    localparam int POS_W = 9;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_COOL = 2'd2
    } state_t;

    function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
        return 4'b0001 << dir;
    endfunction

endpackage

// File: rtl/laser_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin pick: the first pending tunnel after the
// most recently granted one wins, with the last grant itself lowest priority.
module rr_arbiter4 (
    input  logic [3:0] i_pending,
    input  logic [1:0] i_rr_last,
    output logic       o_grant_valid,
    output logic [1:0] o_grant_idx
);

    logic [1:0] w_idx;

    // Scanning from furthest to nearest lets the nearest set bit overwrite.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = 2'd0;
        w_idx         = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = i_rr_last + 2'(k);
            if (i_pending[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/laser_scheduler.sv
// Shared-laser controller for the four cannons: edge capture, round-robin
// grant, laser flight, hit/miss resolution and cooldown. Macro LASER_QUEUE_EN
// lets button edges queue while busy; undefined, edges are taken only in IDLE.
module laser_scheduler
    import laser_pkg::*;
#(
    parameter int LASER_START = 256,
    parameter int STEP        = 2,
    parameter int HIT_POS     = 76,
    parameter int COOLDOWN    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic [3:0]       i_req,
    input  logic [3:0]       i_monster_present,
    output logic [POS_W-1:0] o_laser_pos,
    output logic [1:0]       o_laser_dir,
    output logic [3:0]       o_shooting,
    output logic [3:0]       o_hit_pulse,
    output logic             o_miss_pulse,
    output logic             o_busy
);

    localparam logic [POS_W-1:0] LP_START = POS_W'(LASER_START);
    localparam logic [POS_W-1:0] LP_STEP  = POS_W'(STEP);
    localparam logic [POS_W-1:0] LP_HIT   = POS_W'(HIT_POS);
    localparam logic [7:0]       LP_COOL  = 8'(COOLDOWN);

    state_t           r_state, w_next_state;
    logic [3:0]       r_req_d, r_pending;
    logic [1:0]       r_rr_last, r_laser_dir;
    logic [POS_W-1:0] r_laser_pos;
    logic [7:0]       r_cool;
    logic [3:0]       r_hit_pulse;
    logic             r_miss_pulse;

    logic             w_grant_valid, w_grant, w_hit, w_miss, w_cool_done;
    logic [1:0]       w_grant_idx;
    logic [3:0]       w_rise, w_grant_mask;

    rr_arbiter4 u_arbiter (
        .i_pending     (r_pending),
        .i_rr_last     (r_rr_last),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    assign w_rise       = i_req & ~r_req_d;
    assign w_grant      = (r_state == ST_IDLE) && w_grant_valid;
    assign w_grant_mask = dir_onehot(w_grant_idx);
    // Monster presence only matters on the exact tick the laser sits at HIT_POS.
    assign w_hit        = (r_state == ST_FIRE) && i_tick
                          && i_monster_present[r_laser_dir] && (r_laser_pos == LP_HIT);
    assign w_miss       = (r_state == ST_FIRE) && i_tick && !w_hit
                          && (r_laser_pos == '0);
    assign w_cool_done  = (r_state == ST_COOL) && i_tick && (r_cool <= 8'd1);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (w_grant_valid)    w_next_state = ST_FIRE;
            ST_FIRE: if (w_hit || w_miss)  w_next_state = ST_COOL;
            ST_COOL: if (w_cool_done)      w_next_state = ST_IDLE;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (r_state != ST_IDLE);
        o_shooting = (r_state == ST_FIRE) ? dir_onehot(r_laser_dir) : 4'b0000;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_req_d      <= i_req;
            r_pending    <= 4'b0000;
            r_rr_last    <= 2'd3;
            r_laser_pos  <= LP_START;
            r_laser_dir  <= DIR_UP;
            r_cool       <= 8'd0;
            r_hit_pulse  <= 4'b0000;
            r_miss_pulse <= 1'b0;
        end else begin
            r_req_d      <= i_req;
            r_hit_pulse  <= 4'b0000;
            r_miss_pulse <= 1'b0;
`ifdef LASER_QUEUE_EN
            r_pending <= (r_pending & ~(w_grant ? w_grant_mask : 4'b0000)) | w_rise;
`else
            if (r_state == ST_IDLE)
                r_pending <= w_grant ? 4'b0000 : (r_pending | w_rise);
`endif
            if (w_grant) begin
                r_laser_dir <= w_grant_idx;
                r_rr_last   <= w_grant_idx;
                r_laser_pos <= LP_START;
            end else if (w_hit || w_miss) begin
                r_laser_pos <= LP_START;
                if (w_hit) r_hit_pulse  <= dir_onehot(r_laser_dir);
                else       r_miss_pulse <= 1'b1;
            end else if ((r_state == ST_FIRE) && i_tick) begin
                r_laser_pos <= r_laser_pos - LP_STEP;
            end
            if (w_hit || w_miss)
                r_cool <= LP_COOL;
            else if (w_cool_done || ((r_state == ST_COOL) && i_tick))
                r_cool <= r_cool - 8'd1;
        end
    end

    assign o_laser_pos  = r_laser_pos;
    assign o_laser_dir  = r_laser_dir;
    assign o_hit_pulse  = r_hit_pulse;
    assign o_miss_pulse = r_miss_pulse;

endmodule

// File: tb/tb_laser_scheduler.sv
// Directed self-checking bench for laser_scheduler; exercises the queued
// behaviour when built with LASER_QUEUE_EN, the drop-while-busy one otherwise.
module tb_laser_scheduler;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic [3:0] i_req;
    logic [3:0] i_monster_present;
    logic [8:0] o_laser_pos;
    logic [1:0] o_laser_dir;
    logic [3:0] o_shooting;
    logic [3:0] o_hit_pulse;
    logic       o_miss_pulse;
    logic       o_busy;

    int   nChecks = 0;
    int   nPass   = 0;
    logic [3:0] seenHit;
    logic       seenMiss;

    laser_scheduler dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_tick            (i_tick),
        .i_req             (i_req),
        .i_monster_present (i_monster_present),
        .o_laser_pos       (o_laser_pos),
        .o_laser_dir       (o_laser_dir),
        .o_shooting        (o_shooting),
        .o_hit_pulse       (o_hit_pulse),
        .o_miss_pulse      (o_miss_pulse),
        .o_busy            (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("[TB] FAIL %s: observed %0d required %0d", tag, observed, expected);
    endtask

    // One-cycle button pulse: pending is set one edge later, grant the next.
    task automatic applyStimulus(input logic [3:0] pattern);
        i_req = pattern;
        cycles(1);
        i_req = 4'b0000;
        cycles(1);
    endtask

    task automatic applyTick();
        i_tick = 1'b1;
        cycles(1);
        i_tick = 1'b0;
        seenHit  = seenHit | o_hit_pulse;
        seenMiss = seenMiss | o_miss_pulse;
    endtask

    task automatic flyTicks(input int n);
        repeat (n) begin
            applyTick();
            cycles(3);
        end
    endtask

    // Resolving tick, pulse checks, then the four-tick cooldown back to IDLE.
    task automatic resolveShot(input string tag, input logic [1:0] dir,
                               input bit expectHit);
        checkOutput({tag, " pos before resolve"}, 32'(o_laser_pos),
                    expectHit ? 32'd76 : 32'd0);
        checkOutput({tag, " no early pulse"}, 32'({seenHit, seenMiss}), 32'd0);
        applyTick();
        checkOutput({tag, " hit_pulse"}, 32'(o_hit_pulse),
                    expectHit ? 32'(4'b0001 << dir) : 32'd0);
        checkOutput({tag, " miss_pulse"}, 32'(o_miss_pulse), expectHit ? 32'd0 : 32'd1);
        checkOutput({tag, " pos reload"}, 32'(o_laser_pos), 32'd256);
        checkOutput({tag, " shooting drop"}, 32'(o_shooting), 32'd0);
        cycles(1);
        checkOutput({tag, " pulse one cycle"}, 32'({o_hit_pulse, o_miss_pulse}), 32'd0);
        cycles(2);
        flyTicks(3);
        checkOutput({tag, " busy in cooldown"}, 32'(o_busy), 32'd1);
        applyTick();
        checkOutput({tag, " idle after cooldown"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_tick = 1'b0;
        i_req = 4'b0000;
        i_monster_present = 4'b0000;
        seenHit = 4'b0000;
        seenMiss = 1'b0;
        cycles(2);
        checkOutput("reset pos", 32'(o_laser_pos), 32'd256);
        checkOutput("reset dir", 32'(o_laser_dir), 32'd0);
        checkOutput("reset outputs", 32'({o_shooting, o_hit_pulse, o_miss_pulse, o_busy}), 32'd0);
        i_reset = 1'b0;
        cycles(1);

        $display("[TB] single hit on up tunnel");
        i_monster_present = 4'b0001;
        i_req = 4'b0001;
        cycles(1);
        checkOutput("hit no grant yet", 32'(o_busy), 32'd0);
        i_req = 4'b0000;
        cycles(1);
        checkOutput("hit busy at grant", 32'(o_busy), 32'd1);
        checkOutput("hit shooting", 32'(o_shooting), 32'b0001);
        seenHit = 4'b0000; seenMiss = 1'b0;
        flyTicks(90);
        resolveShot("hit", 2'd0, 1'b1);

        $display("[TB] miss on left tunnel");
        i_monster_present = 4'b0000;
        applyStimulus(4'b0100);
        checkOutput("miss dir", 32'(o_laser_dir), 32'd2);
        checkOutput("miss shooting", 32'(o_shooting), 32'b0100);
        seenHit = 4'b0000; seenMiss = 1'b0;
        flyTicks(128);
        resolveShot("miss", 2'd2, 1'b0);

        $display("[TB] monster leaves mid-flight");
        i_monster_present = 4'b0001;
        applyStimulus(4'b0001);
        checkOutput("leave dir", 32'(o_laser_dir), 32'd0);
        seenHit = 4'b0000; seenMiss = 1'b0;
        flyTicks(40);
        i_monster_present = 4'b0000;
        flyTicks(88);
        resolveShot("leave", 2'd0, 1'b0);

        $display("[TB] press while busy");
        i_monster_present = 4'b0001;
        applyStimulus(4'b0001);
        checkOutput("busy-press dir", 32'(o_laser_dir), 32'd0);
        seenHit = 4'b0000; seenMiss = 1'b0;
        flyTicks(10);
        applyStimulus(4'b0010);
        flyTicks(80);
        resolveShot("busy-press", 2'd0, 1'b1);
        cycles(3);
`ifdef LASER_QUEUE_EN
        checkOutput("queued shot dir", 32'(o_laser_dir), 32'd1);
        checkOutput("queued shooting", 32'(o_shooting), 32'b0010);
        seenHit = 4'b0000; seenMiss = 1'b0;
        flyTicks(128);
        resolveShot("queued", 2'd1, 1'b0);
`else
        checkOutput("dropped press busy", 32'(o_busy), 32'd0);
        checkOutput("dropped press shooting", 32'(o_shooting), 32'd0);
`endif

        $display("[TB] reset mid-shot with right held");
        i_monster_present = 4'b0000;
        i_req = 4'b1000;
        cycles(2);
        checkOutput("held dir", 32'(o_laser_dir), 32'd3);
        flyTicks(53);
        checkOutput("pos before reset", 32'(o_laser_pos), 32'd150);
        i_reset = 1'b1;
        cycles(1);
        i_reset = 1'b0;
        checkOutput("mid reset pos", 32'(o_laser_pos), 32'd256);
        checkOutput("mid reset dir", 32'(o_laser_dir), 32'd0);
        checkOutput("mid reset outputs",
                    32'({o_shooting, o_hit_pulse, o_miss_pulse, o_busy}), 32'd0);
        cycles(4);
        checkOutput("held no grant", 32'(o_busy), 32'd0);
        i_req = 4'b0000;
        cycles(2);

        $display("[TB] simultaneous requests");
        i_monster_present = 4'b1111;
        applyStimulus(4'b1111);
`ifdef LASER_QUEUE_EN
        for (int d = 0; d < 4; d++) begin
            checkOutput("rr dir", 32'(o_laser_dir), 32'(d));
            checkOutput("rr shooting", 32'(o_shooting), 32'(4'b0001 << d));
            seenHit = 4'b0000; seenMiss = 1'b0;
            flyTicks(90);
            resolveShot("rr", 2'(d), 1'b1);
            if (d < 3) cycles(1);
        end
        cycles(3);
        checkOutput("rr all served", 32'(o_busy), 32'd0);
        applyStimulus(4'b1111);
        checkOutput("rr second round dir", 32'(o_laser_dir), 32'd0);
        checkOutput("rr second round busy", 32'(o_busy), 32'd1);
`else
        checkOutput("single dir", 32'(o_laser_dir), 32'd0);
        seenHit = 4'b0000; seenMiss = 1'b0;
        flyTicks(90);
        resolveShot("single", 2'd0, 1'b1);
        cycles(3);
        checkOutput("single only one shot", 32'(o_busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
